// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution frame sequencer.
package conv_pkg;

    localparam int unsigned PIX_W = 8;
    localparam int unsigned RES_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN,
        DONE
    } seq_state_e;

    // Number of valid 3x3 convolution results for a W x H frame.
    function automatic int unsigned calc_n_out(input int unsigned w, input int unsigned h);
        return (w - 2) * (h - 2);
    endfunction

endpackage

// File: rtl/conv_frame_sequencer_if.sv
// Stream signals between the frame reader, the sequencer and the convolution pipeline.
interface conv_frame_sequencer_if;
    import conv_pkg::*;

    logic             s_valid;
    logic [PIX_W-1:0] s_data;
    logic             s_ready;
    logic             pipe_valid;
    logic [PIX_W-1:0] pipe_data;
    logic             pipe_idle;
    logic             conv_done;
    logic [RES_W-1:0] conv_data;
    logic             m_valid;
    logic [RES_W-1:0] m_data;

    // Sequencer side.
    modport master (
        input  s_valid, s_data, pipe_idle, conv_done, conv_data,
        output s_ready, pipe_valid, pipe_data, m_valid, m_data
    );

    // Environment side: upstream source, pipeline and result sink.
    modport slave (
        output s_valid, s_data, pipe_idle, conv_done, conv_data,
        input  s_ready, pipe_valid, pipe_data, m_valid, m_data
    );

endinterface

// File: rtl/seq_counter.sv
// Up-counter with synchronous clear and a look-ahead terminal compare:
// o_hit is high in the cycle whose increment brings the count to TERM.
module seq_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned TERM  = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_hit
);

    localparam logic [WIDTH-1:0] TermM1 = WIDTH'(TERM - 1);

    logic [WIDTH-1:0] r_cnt;

    // Count register; clear has priority over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_hit = i_inc & ~i_clr & (r_cnt == TermM1);

endmodule

// File: rtl/conv_frame_sequencer.sv
// Frame-level controller: paces one frame of pixels into the convolution
// pipeline, counts results and flags completion, timeout and overrun.
module conv_frame_sequencer
    import conv_pkg::*;
#(
    parameter int unsigned IMG_W   = 640,
    parameter int unsigned IMG_H   = 480,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_start,
    conv_frame_sequencer_if.master bus,
    output logic                   o_busy,
    output logic                   o_frame_done,
    output logic                   o_err_timeout,
    output logic                   o_err_overrun
);

    localparam int unsigned N_IN  = IMG_W * IMG_H;
    localparam int unsigned N_OUT = calc_n_out(IMG_W, IMG_H);
    localparam int unsigned IN_W  = $clog2(N_IN + 1);
    localparam int unsigned OUT_W = $clog2(N_OUT + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    seq_state_e       r_state;
    seq_state_e       w_state_next;
    logic             r_start_pend;
    logic             r_err_timeout;
    logic             r_err_overrun;
    logic             r_pipe_valid;
    logic [PIX_W-1:0] r_pipe_data;
    logic             r_m_valid;
    logic [RES_W-1:0] r_m_data;

    logic             w_s_ready;
    logic             w_accept;
    logic             w_frame_start;
    logic             w_active;
    logic             w_in_inc;
    logic             w_in_hit;
    logic [IN_W-1:0]  w_in_cnt;
    logic             w_out_inc;
    logic             w_out_hit;
    logic             w_out_full;
    logic [OUT_W-1:0] w_out_cnt;
    logic             w_tmo_clr;
    logic             w_tmo_inc;
    logic             w_tmo_hit;
    logic [TMO_W-1:0] w_tmo_cnt;
    logic             w_overrun;
    logic             w_tmo_set;

    assign w_s_ready     = (r_state == FEED);
    assign w_accept      = bus.s_valid & w_s_ready;
    assign w_frame_start = (r_state == IDLE) & r_start_pend & bus.pipe_idle;
    assign w_active      = (r_state == FEED) | (r_state == DRAIN);

    // Saturation guards keep the counters bounded even if the FSM were to misbehave.
    assign w_in_inc   = w_accept & (w_in_cnt != IN_W'(N_IN));
    assign w_out_full = (w_out_cnt == OUT_W'(N_OUT));
    assign w_out_inc  = w_active & bus.conv_done & ~w_out_full;
    assign w_overrun  = bus.conv_done & ~w_out_inc;
    assign w_tmo_clr  = w_frame_start | bus.conv_done;
    assign w_tmo_inc  = (r_state == DRAIN) & (w_tmo_cnt != TMO_W'(TIMEOUT));

    seq_counter #(
        .WIDTH (IN_W),
        .TERM  (N_IN)
    ) u_in_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_frame_start),
        .i_inc (w_in_inc),
        .o_cnt (w_in_cnt),
        .o_hit (w_in_hit)
    );

    seq_counter #(
        .WIDTH (OUT_W),
        .TERM  (N_OUT)
    ) u_out_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_frame_start),
        .i_inc (w_out_inc),
        .o_cnt (w_out_cnt),
        .o_hit (w_out_hit)
    );

    seq_counter #(
        .WIDTH (TMO_W),
        .TERM  (TIMEOUT)
    ) u_tmo_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_tmo_clr),
        .i_inc (w_tmo_inc),
        .o_cnt (w_tmo_cnt),
        .o_hit (w_tmo_hit)
    );

    // Next-state logic; transitions use look-ahead hits so DONE lands one cycle after the event.
    always_comb begin
        w_state_next = r_state;
        w_tmo_set    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_frame_start) begin
                    w_state_next = FEED;
                end
            end
            FEED: begin
                if (w_in_hit) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_out_full || w_out_hit) begin
                    w_state_next = DONE;
                end else if (w_tmo_hit) begin
                    w_state_next = DONE;
                    w_tmo_set    = 1'b1;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Pending start; only captured while idle, consumed on frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_pend <= 1'b0;
        end else if (w_frame_start) begin
            r_start_pend <= 1'b0;
        end else if (i_start && (r_state == IDLE)) begin
            r_start_pend <= 1'b1;
        end
    end

    // Sticky error flags, cleared when a new frame starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_timeout <= 1'b0;
            r_err_overrun <= 1'b0;
        end else if (w_frame_start) begin
            r_err_timeout <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            if (w_tmo_set) begin
                r_err_timeout <= 1'b1;
            end
            if (w_overrun) begin
                r_err_overrun <= 1'b1;
            end
        end
    end

    // Registered pixel and result paths; data holds between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_valid <= 1'b0;
            r_pipe_data  <= '0;
            r_m_valid    <= 1'b0;
            r_m_data     <= '0;
        end else begin
            r_pipe_valid <= w_accept;
            if (w_accept) begin
                r_pipe_data <= bus.s_data;
            end
            r_m_valid <= bus.conv_done;
            if (bus.conv_done) begin
                r_m_data <= bus.conv_data;
            end
        end
    end

    assign bus.s_ready    = w_s_ready;
    assign bus.pipe_valid = r_pipe_valid;
    assign bus.pipe_data  = r_pipe_data;
    assign bus.m_valid    = r_m_valid;
    assign bus.m_data     = r_m_data;

    assign o_busy        = (r_state != IDLE);
    assign o_frame_done  = (r_state == DONE);
    assign o_err_timeout = r_err_timeout;
    assign o_err_overrun = r_err_overrun;

endmodule

// File: doc/conv_frame_sequencer.md
# conv_frame_sequencer

Frame-level controller for the line-buffer / hold / 3x3 convolution pipeline. It takes one frame of 8-bit pixels from an upstream valid/ready source and paces them into the pipeline as `data_valid`/`data_i` strobes. It counts convolution results against the expected frame total and reports frame completion, a timeout or an overrun. It sits between the frame reader and the convolution top, and is the only driver of the pipeline's input strobe.

## Interface
- `IMG_W`, 640: pixels per row, must be ≥3.
- `IMG_H`, 480: rows per frame, must be ≥3.
- `TIMEOUT`, 4096: maximum idle cycles between results while draining.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to process one frame.
- `s_valid`  in  1  upstream pixel valid.
- `s_data`  in  8  upstream pixel.
- `s_ready`  out  1  sequencer accepts a pixel this cycle.
- `pipe_valid`  out  1  drives pipeline `data_valid`.
- `pipe_data`  out  8  drives pipeline `data_i`.
- `pipe_idle`  in  1  pipeline idle indication.
- `conv_done`  in  1  one-cycle strobe per convolution result.
- `conv_data`  in  16  convolution result.
- `m_valid`  out  1  registered result strobe.
- `m_data`  out  16  registered result.
- `busy`  out  1  high in any state other than IDLE.
- `frame_done`  out  1  one-cycle pulse when a frame ends.
- `err_timeout`  out  1  sticky; set on drain timeout.
- `err_overrun`  out  1  sticky; set on an unexpected result.

## Operation
- **Frame sizes.**
  - `N_IN = IMG_W*IMG_H`.
  - `N_OUT = (IMG_W-2)*(IMG_H-2)`.
  - Counter widths are `$clog2(N_IN+1)`, `$clog2(N_OUT+1)` and `$clog2(TIMEOUT+1)`.
- **IDLE.** A `start` pulse sets `start_pend`. When `start_pend` and `pipe_idle` are both high, go to FEED, clear `start_pend`, clear `in_cnt` and `out_cnt`, and clear both error flags.
- **FEED.**
  - `s_ready = 1`; a pixel is accepted when `s_valid & s_ready`, and `in_cnt` increments on each acceptance.
  - On the acceptance that brings `in_cnt` to `N_IN`, go to DRAIN.
  - Upstream gaps (`s_valid` low) are legal and produce `pipe_valid` low.
- **DRAIN.**
  - `s_ready = 0`; `tmo_cnt` increments every cycle and clears on `conv_done`.
  - When `out_cnt` reaches `N_OUT`, go to DONE.
  - When `tmo_cnt` reaches `TIMEOUT`, set `err_timeout` and go to DONE.
- **DONE.** Assert `frame_done` for one cycle, then go to IDLE.
- **Result counting.**
  - In FEED or DRAIN, each `conv_done` increments `out_cnt` while it is below `N_OUT`.
  - A `conv_done` arriving when `out_cnt == N_OUT`, or in IDLE or DONE, sets `err_overrun`.
  - Every `conv_done` is still forwarded to `m_valid`/`m_data`, with no filtering.
- **Start handling.**
  - `start` while `busy` is ignored and does not set `start_pend`.
  - `start` in the same cycle as a DONE→IDLE transition is ignored.
- **Simultaneous events.** A `conv_done` in the same cycle as the FEED→DRAIN transition is counted normally.
- **Reset.** `rst_n` low at any point (including mid-frame) forces IDLE, clears all counters, clears `start_pend`, and drives every output to 0. Partial-frame state is discarded.

## Timing
- **Input path.** `pipe_valid`/`pipe_data` are registered. A handshake in cycle t gives `pipe_valid = 1` with that pixel in cycle t+1. Otherwise `pipe_valid = 0` and `pipe_data` holds its value.
- **Output path.** `m_valid`/`m_data` follow `conv_done`/`conv_data` with exactly 1 cycle of latency.
- **Combinational ready.** `s_ready` is a function of state only. It is high from the first FEED cycle and low from the first DRAIN cycle.
- **Start latency.** IDLE→FEED takes 1 cycle after `start_pend & pipe_idle` is sampled. The minimum from `start` to first `s_ready` is 2 cycles.
- **Completion.** `frame_done` is asserted in the cycle after the final counted `conv_done` is sampled, or after the timeout is reached.
- **Error flags.** Both errors are sticky until the next frame start or reset.
- **Busy.** `busy` is high in FEED, DRAIN and DONE.

## Structure
- **Shared package `conv_pkg`:**
  - state enum `{IDLE, FEED, DRAIN, DONE}`;
  - `PIX_W = 8` and `RES_W = 16`;
  - a function computing `N_OUT` from `IMG_W`/`IMG_H`.
- **Sub-module `seq_counter`:** a parameterised width counter with `clr`, `inc` and a `hit` terminal-compare output. It is instantiated three times (`in_cnt`, `out_cnt`, `tmo_cnt`).
- **Top level:** the FSM and output registers live directly in `conv_frame_sequencer`.

## Test plan
Configuration is `IMG_W=8`, `IMG_H=6` (`N_IN=48`, `N_OUT=24`), `TIMEOUT=16`.
1. **Full-rate frame.** `start`, `s_valid` held high, pipeline model emits 24 `conv_done` → 48 `pipe_valid` pulses with matching data, 24 `m_valid` one cycle after each strobe, one `frame_done`, no errors.
2. **Gapped input.** `s_valid` toggles 1-0-1-0 → `pipe_valid` mirrors accepted pixels only, `in_cnt` ends at 48, and the sequencer does not enter DRAIN before the 48th acceptance.
3. **Drain timeout.** The model emits only 20 results → `err_timeout` is set 16 cycles after the 20th result, then `frame_done` pulses and `busy` falls.
4. **Overrun.** The model emits 25 results → `err_overrun` is set on the 25th and `m_valid` still shows 25 pulses.
5. **Start gating.** `start` while `pipe_idle=0` → sequencer stays in IDLE until `pipe_idle` rises, then FEED on the next cycle. `start` during FEED has no effect on the following frame.
6. **Reset mid-frame.** `rst_n` low after 30 pixels → all outputs are 0 immediately. A new `start` then processes a full 48-pixel frame correctly.
